bcd_entry_to_bin: RTL and testbench

- Reverse path of the binary-to-decimal display splitter: the operand entry front end of the calculator practice.
- Accepts decimal digits one at a time from the keypad decoder plus a sign key, and echoes tens/units for the 7-segment display.
- On enter, converts the tens/units entry to a Bits-wide binary operand with FlagNeg, in the same encoding the display path consumes: two's complement when negative.
- Presents the result to the ALU with a valid/ready handshake.

---
 rtl/bcd_entry_to_bin_if.sv | 75 +++++++
 rtl/bcd_entry_to_bin.sv | 184 ++++++++++++++++++
 tb/tb_bcd_entry_to_bin.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_entry_to_bin_if.sv
// ---------------------------------------------------------------------------
// bcd_entry_to_bin_if
//   Bundles the keypad-side entry strobes, the display echo and the
//   result handshake of bcd_entry_to_bin into one connection.
//
//   Parameter
//     Bits        width of the converted operand (must match the block)
//
//   Signals
//     digit       [3:0]   BCD digit from the keypad decoder
//     digit_valid         one-cycle strobe, digit is valid
//     sign_toggle         one-cycle strobe, toggles the entry sign
//     clear               one-cycle strobe, aborts entry or output
//     enter               one-cycle strobe, commits the entry
//     in_ready            block accepts digits, sign or enter
//     tens, unit  [3:0]   display echo of the registered entry
//     value  [Bits-1:0]   converted operand, two's complement if FlagNeg
//     FlagNeg             operand is negative
//     ovf                 magnitude was saturated to 2^Bits-1
//     out_valid           value/FlagNeg/ovf are valid
//     out_ready           consumer accepts the result
//
//   Modports
//     master   keypad decoder + ALU side (drives strobes and out_ready)
//     slave    the entry block itself
// ---------------------------------------------------------------------------
interface bcd_entry_to_bin_if #(
   parameter int Bits = 7
);
   logic [3:0]      digit;
   logic            digit_valid;
   logic            sign_toggle;
   logic            clear;
   logic            enter;
   logic            in_ready;
   logic [3:0]      tens;
   logic [3:0]      unit;
   logic [Bits-1:0] value;
   logic            FlagNeg;
   logic            ovf;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output digit,
      output digit_valid,
      output sign_toggle,
      output clear,
      output enter,
      output out_ready,
      input  in_ready,
      input  tens,
      input  unit,
      input  value,
      input  FlagNeg,
      input  ovf,
      input  out_valid
   );

   modport slave (
      input  digit,
      input  digit_valid,
      input  sign_toggle,
      input  clear,
      input  enter,
      input  out_ready,
      output in_ready,
      output tens,
      output unit,
      output value,
      output FlagNeg,
      output ovf,
      output out_valid
   );
endinterface

// File: rtl/bcd_entry_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_entry_to_bin
//   Operand entry front end: collects up to two decimal digits and a sign
//   from the keypad decoder, echoes them as tens/unit for the 7-segment
//   display, and on enter converts the entry into a Bits-wide binary
//   operand (two's complement when negative, saturated with ovf when the
//   magnitude exceeds 2^Bits-1). The result is offered to the ALU with a
//   valid/ready handshake and held until accepted.
//
//   Parameter
//     Bits       operand width; must equal the interface's Bits
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        bcd_entry_to_bin_if.slave (entry strobes, display echo,
//                result handshake)
//
//   Build option
//     BCD_ENTRY_AUTO_ENTER_EN  when defined, completing a two-digit entry
//                              starts conversion on the following edge
//                              without an explicit enter.
//
//   Priority each cycle: clear > enter > {digit_valid, sign_toggle}.
// ---------------------------------------------------------------------------
module bcd_entry_to_bin #(
   parameter int Bits = 7
) (
   input logic               clk,
   input logic               rst_n,
   bcd_entry_to_bin_if.slave bus
);

   // Magnitude is formed four bits wider than the operand so 99 fits
   // before saturation for any practical Bits.
   localparam int W = Bits + 4;
   localparam logic [W-1:0] MAXW = {{4{1'b0}}, {Bits{1'b1}}};

   typedef enum logic [2:0] {
      IDLE,
      ONE,
      TWO,
      CONV,
      HOLD
   } state_t;

   state_t          state;
   state_t          nxt;

   logic            in_ready_q;
   logic [3:0]      tens_q;
   logic [3:0]      unit_q;
   logic            sign_q;
   logic [Bits-1:0] value_q;
   logic            neg_q;
   logic            ovf_q;
   logic            out_valid_q;

   logic            digit_ok;
   logic            entering;
   logic [W-1:0]    tens_w;
   logic [W-1:0]    unit_w;
   logic [W-1:0]    mag_raw;
   logic [W-1:0]    mag_sat;
   logic            sat;
   logic            neg;
   logic [Bits-1:0] mag_neg;

   // -----------------------------------------------------------------------
   // Next-state selection
   // -----------------------------------------------------------------------
   always_comb begin
      digit_ok = bus.digit_valid && (bus.digit <= 4'd9);
      entering = (state == IDLE) || (state == ONE) || (state == TWO);
      nxt      = state;
      if (bus.clear) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.enter)
                  nxt = CONV;
               else if (digit_ok)
                  nxt = ONE;
            end
            ONE: begin
               if (bus.enter)
                  nxt = CONV;
               else if (digit_ok)
                  nxt = TWO;
            end
            TWO: begin
`ifdef BCD_ENTRY_AUTO_ENTER_EN
               // A completed two-digit entry converts on the next edge.
               nxt = CONV;
`else
               if (bus.enter)
                  nxt = CONV;
`endif
            end
            CONV: nxt = HOLD;
            HOLD: begin
               if (out_valid_q && bus.out_ready)
                  nxt = IDLE;
            end
            default: nxt = IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Conversion datapath: mag = tens*10 + unit as shift-and-add
   // -----------------------------------------------------------------------
   always_comb begin
      tens_w  = W'(tens_q);
      unit_w  = W'(unit_q);
      mag_raw = (tens_w << 3) + (tens_w << 1) + unit_w;
      sat     = (mag_raw > MAXW);
      mag_sat = sat ? MAXW : mag_raw;
      // Negative zero is reported as +0.
      neg     = sign_q && (mag_sat != '0);
      mag_neg = ~mag_sat[Bits-1:0] + Bits'(1);
   end

   // -----------------------------------------------------------------------
   // State and registered outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         tens_q      <= '0;
         unit_q      <= '0;
         sign_q      <= 1'b0;
         value_q     <= '0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state      <= nxt;
         in_ready_q <= (nxt == IDLE) || (nxt == ONE) || (nxt == TWO);
         if (bus.clear) begin
            tens_q      <= '0;
            unit_q      <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
         end else if (entering) begin
            // enter swallows any digit/sign strobe in the same cycle.
            if (!bus.enter) begin
               if (digit_ok && (state != TWO)) begin
                  unit_q <= bus.digit;
                  tens_q <= (state == ONE) ? unit_q : 4'd0;
               end
               if (bus.sign_toggle)
                  sign_q <= ~sign_q;
            end
         end else if (state == CONV) begin
            value_q     <= neg ? mag_neg : mag_sat[Bits-1:0];
            neg_q       <= neg;
            ovf_q       <= sat;
            out_valid_q <= 1'b1;
         end else if (state == HOLD) begin
            // value/FlagNeg stay as the last result after acceptance.
            if (out_valid_q && bus.out_ready) begin
               out_valid_q <= 1'b0;
               ovf_q       <= 1'b0;
               tens_q      <= '0;
               unit_q      <= '0;
               sign_q      <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.tens      = tens_q;
   assign bus.unit      = unit_q;
   assign bus.value     = value_q;
   assign bus.FlagNeg   = neg_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_to_bin
//   Two instances (Bits=7 and Bits=5) share one stimulus stream. A digit
//   list / sign / phase model predicts every output; it is compared on each
//   falling edge. Directed sequences pin the model with literal values,
//   then a random phase exercises arbitrary strobe mixes.
// ---------------------------------------------------------------------------
module tb_bcd_entry_to_bin;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] digit;
   logic       digit_valid;
   logic       sign_toggle;
   logic       clear;
   logic       enter;
   logic       out_ready;

   always #5 clk = ~clk;

   bcd_entry_to_bin_if #(.Bits(7)) bus7 ();
   bcd_entry_to_bin_if #(.Bits(5)) bus5 ();

   assign bus7.digit       = digit;
   assign bus7.digit_valid = digit_valid;
   assign bus7.sign_toggle = sign_toggle;
   assign bus7.clear       = clear;
   assign bus7.enter       = enter;
   assign bus7.out_ready   = out_ready;
   assign bus5.digit       = digit;
   assign bus5.digit_valid = digit_valid;
   assign bus5.sign_toggle = sign_toggle;
   assign bus5.clear       = clear;
   assign bus5.enter       = enter;
   assign bus5.out_ready   = out_ready;

   bcd_entry_to_bin #(.Bits(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));
   bcd_entry_to_bin #(.Bits(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: entered digits as a list, sign bit, phase
   // ------------------------------------------------------------------
   localparam int PH_ENTRY = 0;
   localparam int PH_CONV  = 1;
   localparam int PH_HOLD  = 2;

   int dq[$];
   bit msign;
   int phase;
   bit mvalid;
   int mval[2];
   bit mneg[2];
   bit movf[2];

   function automatic int bits_of(input int k);
      return (k == 0) ? 7 : 5;
   endfunction

   function automatic int exp_tens();
      return (dq.size() == 2) ? dq[0] : 0;
   endfunction

   function automatic int exp_unit();
      return (dq.size() > 0) ? dq[dq.size()-1] : 0;
   endfunction

   task automatic convert(input int bits, input int t, input int u, input bit s,
                          output int v, output bit n, output bit o);
      int maxv;
      int m;
      maxv = (1 << bits) - 1;
      m    = t * 10 + u;
      o    = (m > maxv);
      if (o) m = maxv;
      n = s && (m != 0);
      v = n ? ((1 << bits) - m) : m;
   endtask

   task automatic mdl_reset();
      dq.delete();
      msign  = 1'b0;
      phase  = PH_ENTRY;
      mvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mval[k] = 0;
         mneg[k] = 1'b0;
         movf[k] = 1'b0;
      end
   endtask

   task automatic mdl_step();
      if (clear) begin
         dq.delete();
         msign  = 1'b0;
         phase  = PH_ENTRY;
         mvalid = 1'b0;
         for (int k = 0; k < 2; k++) movf[k] = 1'b0;
      end else begin
         case (phase)
            PH_ENTRY: begin
               if (enter) begin
                  phase = PH_CONV;
               end else begin
`ifdef BCD_ENTRY_AUTO_ENTER_EN
                  if (dq.size() == 2) phase = PH_CONV;
`endif
                  if (digit_valid && (digit <= 4'd9) && (dq.size() < 2))
                     dq.push_back(int'(digit));
                  if (sign_toggle) msign = !msign;
               end
            end
            PH_CONV: begin
               for (int k = 0; k < 2; k++)
                  convert(bits_of(k), exp_tens(), exp_unit(), msign,
                          mval[k], mneg[k], movf[k]);
               mvalid = 1'b1;
               phase  = PH_HOLD;
            end
            default: begin
               if (out_ready) begin
                  mvalid = 1'b0;
                  for (int k = 0; k < 2; k++) movf[k] = 1'b0;
                  dq.delete();
                  msign = 1'b0;
                  phase = PH_ENTRY;
               end
            end
         endcase
      end
   endtask

   task automatic cmp_all();
      check("in_ready7",  int'(bus7.in_ready),  int'(phase == PH_ENTRY));
      check("in_ready5",  int'(bus5.in_ready),  int'(phase == PH_ENTRY));
      check("tens7",      int'(bus7.tens),      exp_tens());
      check("unit7",      int'(bus7.unit),      exp_unit());
      check("tens5",      int'(bus5.tens),      exp_tens());
      check("unit5",      int'(bus5.unit),      exp_unit());
      check("out_valid7", int'(bus7.out_valid), int'(mvalid));
      check("out_valid5", int'(bus5.out_valid), int'(mvalid));
      check("ovf7",       int'(bus7.ovf),       int'(movf[0]));
      check("ovf5",       int'(bus5.ovf),       int'(movf[1]));
      if (mvalid) begin
         check("value7",   int'(bus7.value),   mval[0]);
         check("FlagNeg7", int'(bus7.FlagNeg), int'(mneg[0]));
         check("value5",   int'(bus5.value),   mval[1]);
         check("FlagNeg5", int'(bus5.FlagNeg), int'(mneg[1]));
      end
   endtask

   // Inputs change only 1 time unit after a rising edge, so at the falling
   // edge they are exactly what the next rising edge will sample.
   initial begin
      mdl_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) mdl_reset();
         cmp_all();
         if (rst_n) mdl_step();
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic cyc(input int d, input bit dv, input bit st, input bit clr,
                      input bit ent, input bit ordy);
      @(posedge clk);
      #1;
      digit       = 4'(d);
      digit_valid = dv;
      sign_toggle = st;
      clear       = clr;
      enter       = ent;
      out_ready   = ordy;
   endtask

   task automatic idle();
      cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic key(input int d);
      cyc(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_enter();
      cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic accept();
      cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
   endtask

   initial begin
      rst_n       = 1'b1;
      digit       = '0;
      digit_valid = 1'b0;
      sign_toggle = 1'b0;
      clear       = 1'b0;
      enter       = 1'b0;
      out_ready   = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_value",     int'(bus7.value),     0);
      check("rst_flagneg",   int'(bus7.FlagNeg),   0);
      check("rst_ovf",       int'(bus7.ovf),       0);
      check("rst_out_valid", int'(bus7.out_valid), 0);
      check("rst_in_ready",  int'(bus7.in_ready),  1);
      check("rst_tens",      int'(bus7.tens),      0);
      check("rst_unit",      int'(bus7.unit),      0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 4, 7, enter -> 47; Bits=5 saturates to 31
      key(4);
      key(7);
      check("one_digit_unit", int'(bus7.unit), 4);
      press_enter();
      check("entry_tens", int'(bus7.tens), 4);
      check("entry_unit", int'(bus7.unit), 7);
      idle();
      check("conv_in_ready", int'(bus7.in_ready), 0);
      idle();
      check("d47_value7",   int'(bus7.value),     47);
      check("d47_neg7",     int'(bus7.FlagNeg),   0);
      check("d47_ovf7",     int'(bus7.ovf),       0);
      check("d47_valid7",   int'(bus7.out_valid), 1);
      check("d47_value5",   int'(bus5.value),     31);
      check("d47_ovf5",     int'(bus5.ovf),       1);
      // Back-pressure: strobes ignored while held
      for (int i = 0; i < 5; i++) begin
         cyc(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         check("hold_valid",    int'(bus7.out_valid), 1);
         check("hold_value",    int'(bus7.value),     47);
         check("hold_in_ready", int'(bus7.in_ready),  0);
         check("hold_unit",     int'(bus7.unit),      7);
      end
      accept();
      check("acc_valid",    int'(bus7.out_valid), 0);
      check("acc_in_ready", int'(bus7.in_ready),  1);
      check("acc_tens",     int'(bus7.tens),      0);
      check("acc_ovf5",     int'(bus5.ovf),       0);

      // 2, 5, sign, enter -> -25
      key(2);
      key(5);
      cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      press_enter();
      idle();
      idle();
      check("neg25_value7", int'(bus7.value),   7'b1100111);
      check("neg25_neg7",   int'(bus7.FlagNeg), 1);
      check("neg25_value5", int'(bus5.value),   5'b00111);
      check("neg25_neg5",   int'(bus5.FlagNeg), 1);
      accept();
      check("neg25_clr_tens", int'(bus7.tens), 0);
      check("neg25_clr_unit", int'(bus7.unit), 0);

      // 9, 9, 3 (third ignored), enter
      key(9);
      key(9);
      key(3);
      press_enter();
      check("third_tens", int'(bus7.tens), 9);
      check("third_unit", int'(bus7.unit), 9);
      idle();
      idle();
      check("d99_value5", int'(bus5.value),   31);
      check("d99_ovf5",   int'(bus5.ovf),     1);
      check("d99_neg5",   int'(bus5.FlagNeg), 0);
      check("d99_value7", int'(bus7.value),   99);
      accept();

      // Sign only, invalid digit 12, enter -> +0
      cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      press_enter();
      check("bad_digit_unit",  int'(bus7.unit),     0);
      check("bad_digit_ready", int'(bus7.in_ready), 1);
      idle();
      idle();
      check("negzero_value", int'(bus7.value),     0);
      check("negzero_neg",   int'(bus7.FlagNeg),   0);
      check("negzero_valid", int'(bus7.out_valid), 1);
      accept();

      // clear in TWO
      key(1);
      key(2);
      cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
      check("clr_two_valid", int'(bus7.out_valid), 0);
      check("clr_two_unit",  int'(bus7.unit),      0);
      check("clr_two_ready", int'(bus7.in_ready),  1);
      // clear in HOLD wins over enter and handshake
      key(6);
      press_enter();
      idle();
      idle();
      check("d6_value", int'(bus7.value), 6);
      cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle();
      check("clr_hold_valid", int'(bus7.out_valid), 0);
      check("clr_hold_ready", int'(bus7.in_ready),  1);
      // clear drops a pending sign
      cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      key(4);
      press_enter();
      idle();
      idle();
      check("clr_sign_neg", int'(bus7.FlagNeg), 0);
      accept();

      // Async reset mid-entry
      key(5);
      key(3);
      idle();
      check("pre_rst_tens", int'(bus7.tens), 5);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_tens",  int'(bus7.tens),     0);
      check("mid_rst_unit",  int'(bus7.unit),     0);
      check("mid_rst_ready", int'(bus7.in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // Async reset mid-HOLD
      key(8);
      press_enter();
      idle();
      idle();
      check("pre_rst_valid", int'(bus7.out_valid), 1);
      #3 rst_n = 1'b0;
      #1;
      check("hold_rst_valid", int'(bus7.out_valid), 0);
      check("hold_rst_value", int'(bus7.value),     0);
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef BCD_ENTRY_AUTO_ENTER_EN
      key(3);
      key(8);
      idle();
      idle();
      idle();
      check("auto_value", int'(bus7.value),     38);
      check("auto_valid", int'(bus7.out_valid), 1);
      accept();
`endif

      // Random strobe mix
      for (int i = 0; i < 3000; i++) begin
         cyc(int'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < 40),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 10),
             ($urandom_range(0, 99) < 50));
      end
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
